// File: rtl/stack_arbiter.sv
// stack_arbiter
//   Two-port round-robin front end for a single push/pop LIFO. Each
//   transaction runs IDLE -> EXEC -> DONE. In IDLE the winner and its op are
//   latched, and the strobe is registered so that it is driven during EXEC.
//   Occupancy moves at the edge that closes EXEC, and the ack is given in DONE.
//   The stack's own reset must be the inverse of `reset`. Its contents then
//   agree with `count` after any reset, including one in mid-transaction.
// Ports
//   clk, reset          clock, async active-low reset
//   reqN/opN/dinN       requester N: request, op (1=push, 0=pop), push data
//   ackN                one-cycle completion pulse to requester N
//   rdata, err          popped data / rejection flag, valid in the ack cycle only
//   count, full, empty  occupancy
//   fault               sticky: stack flagged an error on a legal op
//   stk_*               strobes/data to the stack, top-of-stack and error from it
module stack_arbiter #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req0,
   input  logic                       req1,
   input  logic                       op0,
   input  logic                       op1,
   input  logic [WIDTH-1:0]           din0,
   input  logic [WIDTH-1:0]           din1,
   output logic                       ack0,
   output logic                       ack1,
   output logic [WIDTH-1:0]           rdata,
   output logic                       err,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       fault,
   output logic                       stk_push,
   output logic                       stk_pop,
   output logic [WIDTH-1:0]           stk_data_in,
   input  logic [WIDTH-1:0]           stk_data_out,
   input  logic                       stk_error
);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   state_t state_q, state_d;

   logic             win_q, win_d;          // winner id: 0 or 1
   logic             last_q, last_d;        // last-granted requester
   logic             err_q, err_d;          // latched rejection of current op
   logic             fault_q, fault_d;
   logic             stk_push_q, stk_push_d;
   logic             stk_pop_q, stk_pop_d;
   logic [WIDTH-1:0] stk_data_in_q, stk_data_in_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [CW-1:0]    count_q, count_d;

   // Round robin: requester 1 wins only when alone, or on a tie when 0 went last.
   logic             gnt1, w_op, legal;
   logic [WIDTH-1:0] w_din;
   assign gnt1  = req1 & (~req0 | ~last_q);
   assign w_op  = gnt1 ? op1  : op0;
   assign w_din = gnt1 ? din1 : din0;
   // count is stable from IDLE through EXEC, so legality can be decided at grant time.
   assign legal = w_op ? (count_q != DEPTH_C) : (count_q != '0);

   // ---- state register + datapath flops ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         win_q         <= 1'b0;
         last_q        <= 1'b1;
         err_q         <= 1'b0;
         fault_q       <= 1'b0;
         stk_push_q    <= 1'b0;
         stk_pop_q     <= 1'b0;
         stk_data_in_q <= '0;
         rdata_q       <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         win_q         <= win_d;
         last_q        <= last_d;
         err_q         <= err_d;
         fault_q       <= fault_d;
         stk_push_q    <= stk_push_d;
         stk_pop_q     <= stk_pop_d;
         stk_data_in_q <= stk_data_in_d;
         rdata_q       <= rdata_d;
         count_q       <= count_d;
      end
   end

   // ---- next state ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req0 | req1) state_d = EXEC;
         EXEC:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---- datapath next values ----
   always_comb begin
      win_d         = win_q;
      last_d        = last_q;
      err_d         = err_q;
      fault_d       = fault_q;
      stk_push_d    = stk_push_q;
      stk_pop_d     = stk_pop_q;
      stk_data_in_d = stk_data_in_q;
      rdata_d       = rdata_q;
      count_d       = count_q;
      case (state_q)
         IDLE: if (req0 | req1) begin
            win_d         = gnt1;
            stk_push_d    = w_op & legal;
            stk_pop_d     = ~w_op & legal;
            stk_data_in_d = (w_op & legal) ? w_din : '0;
            err_d         = ~legal;
         end
         EXEC: begin
            stk_push_d    = 1'b0;
            stk_pop_d     = 1'b0;
            stk_data_in_d = '0;
            // Strobes were only raised for legal ops, so no saturation check is needed here.
            if (stk_push_q)     count_d = count_q + CW'(1);
            else if (stk_pop_q) count_d = count_q - CW'(1);
            // The top-of-stack view is still the pre-pop value until this edge.
            rdata_d = stk_pop_q ? stk_data_out : '0;
         end
         DONE: begin
            last_d  = win_q;
            rdata_d = '0;
            // DONE is the cycle after the strobe; err_q=0 means a strobe was issued.
            if (!err_q && stk_error) fault_d = 1'b1;
         end
         default: ;
      endcase
   end

   // ---- outputs ----
   always_comb begin
      ack0        = (state_q == DONE) & ~win_q;
      ack1        = (state_q == DONE) &  win_q;
      err         = (state_q == DONE) & err_q;
      rdata       = (state_q == DONE) ? rdata_q : '0;
      count       = count_q;
      full        = (count_q == DEPTH_C);
      empty       = (count_q == '0);
      fault       = fault_q;
      stk_push    = stk_push_q;
      stk_pop     = stk_pop_q;
      stk_data_in = stk_data_in_q;
   end
endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural 16-entry stack model.
module tb_stack_arbiter;
   logic       clk, reset;
   logic       req0, req1, op0, op1;
   logic [7:0] din0, din1;
   logic       ack0, ack1, err, full, empty, fault;
   logic [7:0] rdata, stk_data_in, stk_data_out;
   logic [4:0] count;
   logic       stk_push, stk_pop, stk_error;

   int n_assert = 0;
   int n_fail   = 0;

   stack_arbiter #(.WIDTH(8), .DEPTH(16)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1), .din0(din0), .din1(din1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .count(count),
      .full(full), .empty(empty), .fault(fault),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
      .stk_data_out(stk_data_out), .stk_error(stk_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stack model, reset from the inverted arbiter reset.
   logic [7:0] mem [16];
   int         sp;
   always @(posedge clk or negedge reset) begin
      if (!reset) sp <= 0;
      else if (stk_push && sp < 16) begin mem[sp] <= stk_data_in; sp <= sp + 1; end
      else if (stk_pop && sp > 0) sp <= sp - 1;
   end
   assign stk_data_out = (sp != 0) ? mem[sp-1] : 8'h00;

   // Strobe monitors (cumulative; tests compare snapshots).
   int n_push = 0, n_pop = 0, n_both = 0;
   always @(posedge clk) begin
      if (stk_push) n_push <= n_push + 1;
      if (stk_pop) n_pop <= n_pop + 1;
      if (stk_push && stk_pop) n_both <= n_both + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // One transaction; lat = negedges from drive to ack (-1 on timeout).
   task automatic do_op(input int port, input logic op, input logic [7:0] d,
                        output int lat, output logic [7:0] rd, output logic e,
                        output logic xpush, output logic xpop);
      @(negedge clk);
      lat = -1; rd = 8'hxx; e = 1'bx; xpush = 1'bx; xpop = 1'bx;
      if (port == 0) begin req0 = 1'b1; op0 = op; din0 = d; end
      else           begin req1 = 1'b1; op1 = op; din1 = d; end
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) begin xpush = stk_push; xpop = stk_pop; end
         if ((port == 0 && ack0) || (port == 1 && ack1)) begin
            lat = c; rd = rdata; e = err; break;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   int         lat, p0, nack;
   logic [7:0] rd;
   logic       e, xp, xq, saw_ack;
   int         order [6];
   logic [7:0] ord_rd [6];
   logic       ord_err [6];

   initial begin
      reset = 1'b0; req0 = 0; req1 = 0; op0 = 0; op1 = 0; din0 = 0; din1 = 0;
      stk_error = 1'b0;
      #3;
      chk("rst_ack0", ack0, 0);       chk("rst_ack1", ack1, 0);
      chk("rst_rdata", rdata, 0);     chk("rst_err", err, 0);
      chk("rst_count", count, 0);     chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);       chk("rst_fault", fault, 0);
      chk("rst_push", stk_push, 0);   chk("rst_pop", stk_pop, 0);
      chk("rst_din", stk_data_in, 0);
      @(negedge clk); reset = 1'b1;

      // Basic push/push/pop.
      do_op(0, 1, 8'hAA, lat, rd, e, xp, xq);
      chk("p1_lat", lat, 2); chk("p1_err", e, 0); chk("p1_strobe", xp, 1);
      do_op(0, 1, 8'h55, lat, rd, e, xp, xq);
      chk("p2_lat", lat, 2); chk("p2_err", e, 0);
      chk("p2_count", count, 2);
      do_op(1, 0, 8'h00, lat, rd, e, xp, xq);
      chk("pop_lat", lat, 2); chk("pop_rdata", rd, 8'h55); chk("pop_err", e, 0);
      chk("pop_strobe", xq, 1); chk("pop_count", count, 1);
      @(negedge clk);
      chk("rdata_idle", rdata, 0);

      // Fill to DEPTH, then one more push.
      do_reset();
      p0 = n_push;
      for (int i = 0; i < 16; i++) begin
         do_op(0, 1, 8'(i), lat, rd, e, xp, xq);
         chk("fill_err", e, 0);
      end
      chk("fill_full", full, 1); chk("fill_count", count, 16);
      chk("fill_pulses", n_push - p0, 16);
      do_op(0, 1, 8'hEE, lat, rd, e, xp, xq);
      chk("ovf_lat", lat, 2); chk("ovf_err", e, 1); chk("ovf_nostrobe", xp, 0);
      chk("ovf_count", count, 16); chk("ovf_pulses", n_push - p0, 16);
      do_op(1, 0, 8'h00, lat, rd, e, xp, xq);
      chk("full_pop_rdata", rd, 8'h0F); chk("full_pop_count", count, 15);

      // Pop from empty.
      do_reset();
      p0 = n_pop;
      do_op(0, 0, 8'h00, lat, rd, e, xp, xq);
      chk("unf_lat", lat, 2); chk("unf_err", e, 1); chk("unf_rdata", rd, 0);
      chk("unf_nostrobe", xq, 0); chk("unf_pulses", n_pop - p0, 0);
      chk("unf_count", count, 0); chk("unf_empty", empty, 1);

      // Both requesters held: 0 pushes 0x11, 1 pops it back.
      do_reset();
      p0 = n_both; nack = 0;
      @(negedge clk);
      req0 = 1; op0 = 1; din0 = 8'h11;
      req1 = 1; op1 = 0; din1 = 8'h00;
      for (int c = 0; c < 40 && nack < 6; c++) begin
         @(negedge clk);
         if (ack0 && ack1) chk("rr_dual_ack", 1, 0);
         if (ack0 || ack1) begin
            order[nack] = ack1 ? 1 : 0; ord_rd[nack] = rdata; ord_err[nack] = err;
            nack++;
         end
      end
      req0 = 0; req1 = 0;
      chk("rr_nack", nack, 6);
      for (int i = 0; i < 6; i++) begin
         chk("rr_order", order[i], i % 2);
         chk("rr_rdata", ord_rd[i], (i % 2) ? 8'h11 : 8'h00);
         chk("rr_err", ord_err[i], 0);
      end
      chk("rr_no_dual_strobe", n_both - p0, 0);

      // Reset during EXEC of a push.
      do_reset();
      do_op(0, 1, 8'h77, lat, rd, e, xp, xq);
      chk("mid_pre_count", count, 1);
      @(negedge clk);
      req0 = 1; op0 = 1; din0 = 8'h99;
      @(posedge clk);
      #2;
      chk("mid_exec_push", stk_push, 1);
      reset = 1'b0;
      #1;
      chk("mid_push", stk_push, 0); chk("mid_din", stk_data_in, 0);
      chk("mid_count", count, 0);   chk("mid_empty", empty, 1);
      chk("mid_full", full, 0);     chk("mid_err", err, 0);
      req0 = 0;
      saw_ack = 0;
      repeat (3) begin @(negedge clk); if (ack0 || ack1) saw_ack = 1; end
      reset = 1'b1;
      repeat (2) begin @(negedge clk); if (ack0 || ack1) saw_ack = 1; end
      chk("mid_no_ack", saw_ack, 0);
      do_op(1, 0, 8'h00, lat, rd, e, xp, xq);
      chk("mid_pop_err", e, 1); chk("mid_pop_rdata", rd, 0);

      // Sticky fault.
      chk("flt_pre", fault, 0);
      stk_error = 1'b1;
      do_op(0, 1, 8'h42, lat, rd, e, xp, xq);
      @(negedge clk);
      stk_error = 1'b0;
      chk("flt_set", fault, 1);
      do_op(1, 0, 8'h00, lat, rd, e, xp, xq);
      do_op(0, 1, 8'h43, lat, rd, e, xp, xq);
      chk("flt_sticky", fault, 1);
      do_reset();
      chk("flt_cleared", fault, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
